drp_responder: RTL and testbench
================================

DRP_RESPONDER -- requirements
Module: drp_responder

Interface
REQ-001 Parameter: ADDR_W, default 8, DRP address width; register bank depth is 2**ADDR_W.
REQ-002 Parameter: DATA_W, default 16, DRP data width.
REQ-003 Parameter: LATENCY, default 3, request-to-drprdy cycles; legal 1..15; elaboration SHALL fail outside this range.
REQ-004 Parameter: DEVICE_ID, default 16'h7A01, read-only content of address 0.
REQ-005 drpclk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 drpen  input  1  transaction request, one-cycle strobe from the initiator.
REQ-008 drpwe  input  1  1 = write, 0 = read; sampled with drpen.
REQ-009 drpaddr  input  ADDR_W  register address; sampled with drpen.
REQ-010 drpdi  input  DATA_W  write data; sampled with drpen.
REQ-011 drprdy  output  1  one-cycle completion strobe.
REQ-012 drpdo  output  DATA_W  read data; valid only while drprdy=1.
REQ-013 busy  output  1  transaction in flight; a new drpen here is a violation.
REQ-014 err  output  1  sticky protocol-violation flag.

Function
REQ-015 The block SHALL be the target end of a DRP link, holding a 2**ADDR_W x DATA_W register bank.
REQ-016 FSM states SHALL be IDLE, WAIT and DONE; reset state is IDLE.
REQ-017 IDLE: drpen=1 at edge k captures drpwe, drpaddr and drpdi, loads the latency counter with LATENCY-1, and moves to WAIT (LATENCY>1) or DONE (LATENCY=1).
REQ-018 WAIT: the counter decrements each cycle; at count 1 the FSM moves to DONE.
REQ-019 drprdy SHALL be 1 for exactly one cycle, the cycle following edge k+LATENCY-1 (i.e. LATENCY cycles after capture), and only in DONE.
REQ-020 busy SHALL be 1 in WAIT only; it is never 1 when LATENCY=1.
REQ-021 DONE accepts drpen exactly as IDLE does, so back-to-back transactions run every LATENCY cycles; without drpen, DONE returns to IDLE.
REQ-022 A write SHALL commit drpdi to the captured address at capture edge k.
REQ-023 A read SHALL latch the bank content at capture edge k; drpdo shows the latched value during the drprdy cycle.
REQ-024 Address 0 SHALL read DEVICE_ID; writes to address 0 complete normally (drprdy pulses) but do not change contents.
REQ-025 drpdo SHALL be all-zero whenever drprdy=0, and during the drprdy cycle of a write.
REQ-026 drpen=1 while busy=1 SHALL be ignored (no capture, no bank change, in-flight transaction unaffected) and SHALL set err.
REQ-027 err SHALL stay 1 until rst_n is asserted; the block otherwise keeps operating normally.
REQ-028 drpwe, drpaddr and drpdi SHALL be ignored in any cycle with drpen=0.

Reset
REQ-029 rst_n=0 SHALL asynchronously force: FSM=IDLE, counter=0, drprdy=0, drpdo=0, busy=0, err=0, and all bank entries at addresses 1..2**ADDR_W-1 to zero.
REQ-030 Reset asserted mid-transaction SHALL abort it with no drprdy pulse afterward; a write captured before reset is cleared by reset.
REQ-031 After rst_n deasserts, the first rising edge SHALL already accept drpen.

Verification
REQ-032 Defaults; read addr 0x00 at edge 0 -> drprdy=1 exactly 3 cycles later with drpdo=16'h7A01; busy=1 for the 2 cycles in between.
REQ-033 Write 0x5A with 16'hBEEF, then read 0x5A issued in the write's drprdy cycle -> second drprdy 3 cycles later with drpdo=16'hBEEF; err=0.
REQ-034 Read 0x10, then drpen (write 0x10, 16'h1234) one cycle later -> err=1; the read returns 16'h0000; a later read of 0x10 returns 16'h0000.
REQ-035 Write 16'hFFFF to addr 0 -> drprdy pulses with drpdo=0; a following read of addr 0 returns 16'h7A01.
REQ-036 Assert rst_n=0 one cycle after a write request to 0x22 with 16'hCAFE -> no drprdy; after release, reading 0x22 returns 16'h0000 and err=0.
REQ-037 LATENCY=1; 8 consecutive-cycle writes then 8 consecutive-cycle reads -> drprdy high every cycle, busy always 0, data matches.

Source files
------------

// File: rtl/drp_responder.sv
// DRP target endpoint: a 2**ADDR_W x DATA_W register bank that answers each
// request with a single drprdy strobe LATENCY cycles after capture.
// Address 0 is a read-only DEVICE_ID. A request that arrives while a
// transaction is in flight is dropped and raises the sticky err flag.
module drp_responder #(
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       LATENCY   = 3,
    parameter logic [DATA_W-1:0] DEVICE_ID = DATA_W'(16'h7A01)
) (
    input  logic              drpclk,
    input  logic              rst_n,
    input  logic              drpen,
    input  logic              drpwe,
    input  logic [ADDR_W-1:0] drpaddr,
    input  logic [DATA_W-1:0] drpdi,
    output logic              drprdy,
    output logic [DATA_W-1:0] drpdo,
    output logic              busy,
    output logic              err
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    if ((LATENCY < 1) || (LATENCY > 15)) begin : g_latency_check
        $error("drp_responder: LATENCY must be in the range 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_e;

    // With LATENCY=1 the response is due in the very next cycle, so WAIT is skipped.
    localparam state_e ST_AFTER_CAPTURE = (LATENCY == 1) ? ST_DONE : ST_WAIT;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              wr_en;

    logic [DATA_W-1:0] bank_q [DEPTH];

    // Next-state logic: capture in IDLE/DONE, count down in WAIT, flag requests that arrive in WAIT.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wr_en   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (drpen) begin
                    state_d = ST_AFTER_CAPTURE;
                    cnt_d   = LAT_M1;
                    we_d    = drpwe;
                    wr_en   = drpwe && (drpaddr != '0);
                    if (drpwe) begin
                        rdata_d = '0;
                    end else if (drpaddr == '0) begin
                        rdata_d = DEVICE_ID;
                    end else begin
                        rdata_d = bank_q[drpaddr];
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                end
                if (drpen) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers: FSM, latency counter, captured direction, read latch, sticky error.
    always_ff @(posedge drpclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Register bank: written at the capture edge; entry 0 is never written (DEVICE_ID is returned instead).
    always_ff @(posedge drpclk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the bank is reset explicitly because software relies on it reading back zero; plain RAM would not.
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else if (wr_en) begin
            bank_q[drpaddr] <= drpdi;
        end
    end

    assign drprdy = (state_q == ST_DONE);
    assign busy   = (state_q == ST_WAIT);
    assign err    = err_q;
    assign drpdo  = (drprdy && !we_q) ? rdata_q : '0;

endmodule

// File: tb/tb_drp_responder.sv
// Bench for drp_responder: one instance at default latency, one at LATENCY=1.
// Each issued request pushes its expected data and arrival cycle to a
// per-instance queue; negedge monitors pop and compare on every drprdy.
module tb_drp_responder;

    localparam logic [15:0] DEV_ID = 16'h7A01;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } sb_item_t;

    logic        drpclk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        drpen_a = 1'b0;
    logic        drpen_b = 1'b0;
    logic        drpwe   = 1'b0;
    logic [7:0]  drpaddr = '0;
    logic [15:0] drpdi   = '0;
    logic        drprdy_a, drprdy_b;
    logic [15:0] drpdo_a, drpdo_b;
    logic        busy_a, busy_b, err_a, err_b;

    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    sb_item_t    sb_a[$];
    sb_item_t    sb_b[$];
    logic [15:0] model_a [256];
    logic [15:0] model_b [256];

    always #5 drpclk = ~drpclk;
    always @(posedge drpclk) cyc <= cyc + 1;

    drp_responder u_dut_a (
        .drpclk (drpclk),  .rst_n (rst_n),   .drpen (drpen_a), .drpwe (drpwe),
        .drpaddr(drpaddr), .drpdi (drpdi),   .drprdy(drprdy_a), .drpdo(drpdo_a),
        .busy   (busy_a),  .err   (err_a)
    );

    drp_responder #(.LATENCY(1)) u_dut_b (
        .drpclk (drpclk),  .rst_n (rst_n),   .drpen (drpen_b), .drpwe (drpwe),
        .drpaddr(drpaddr), .drpdi (drpdi),   .drprdy(drprdy_b), .drpdo(drpdo_b),
        .busy   (busy_b),  .err   (err_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            model_a[i] = '0;
            model_b[i] = '0;
        end
    endtask

    // Drive one request (called just after a rising edge), update the model, push the expectation.
    task automatic issue(input bit b, input logic we, input logic [7:0] addr, input logic [15:0] data);
        sb_item_t it;
        if (we && addr != 8'h00) begin
            if (b) model_b[addr] = data;
            else   model_a[addr] = data;
        end
        if (we)               it.data = '0;
        else if (addr == 8'h00) it.data = DEV_ID;
        else                  it.data = b ? model_b[addr] : model_a[addr];
        it.cyc = cyc + (b ? 1 : 3);
        if (b) sb_b.push_back(it);
        else   sb_a.push_back(it);
        drpwe   = we;
        drpaddr = addr;
        drpdi   = data;
        if (b) drpen_b = 1'b1;
        else   drpen_a = 1'b1;
        @(posedge drpclk);
        #1;
        drpen_a = 1'b0;
        drpen_b = 1'b0;
        drpwe   = 1'($urandom);
        drpaddr = 8'($urandom);
        drpdi   = 16'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && (sb_a.size() != 0 || sb_b.size() != 0); i++) begin
            @(posedge drpclk);
        end
        check("drain_timeout", 32'(sb_a.size() + sb_b.size()), 32'd0);
        @(posedge drpclk);
        #1;
    endtask

    // Monitor for the default-latency instance.
    always @(negedge drpclk) begin
        if (rst_n) begin
            if (drprdy_a) begin
                if (sb_a.size() == 0) begin
                    check("a_spurious_rdy", 32'(drprdy_a), 32'd0);
                end else begin
                    sb_item_t e;
                    e = sb_a.pop_front();
                    check("a_rdata", 32'(drpdo_a), 32'(e.data));
                    check("a_rdy_cycle", cyc, e.cyc);
                end
            end else begin
                check("a_do_zero", 32'(drpdo_a), 32'd0);
                if (sb_a.size() != 0 && sb_a[0].cyc == cyc) check("a_rdy_missing", 32'(drprdy_a), 32'd1);
            end
        end
    end

    // Monitor for the LATENCY=1 instance; busy must never rise.
    always @(negedge drpclk) begin
        if (rst_n) begin
            check("b_busy", 32'(busy_b), 32'd0);
            if (drprdy_b) begin
                if (sb_b.size() == 0) begin
                    check("b_spurious_rdy", 32'(drprdy_b), 32'd0);
                end else begin
                    sb_item_t e;
                    e = sb_b.pop_front();
                    check("b_rdata", 32'(drpdo_b), 32'(e.data));
                    check("b_rdy_cycle", cyc, e.cyc);
                end
            end else if (sb_b.size() != 0 && sb_b[0].cyc == cyc) begin
                check("b_rdy_missing", 32'(drprdy_b), 32'd1);
            end
        end
    end

    initial begin
        logic [7:0] b_addrs [8];
        b_addrs = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF, 8'h33, 8'h5A};
        model_reset();

        // Reset state
        repeat (3) @(posedge drpclk);
        #1;
        check("rst_rdy", 32'(drprdy_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_do", 32'(drpdo_a), 32'd0);
        rst_n = 1'b1;

        // Read DEVICE_ID on the first edge after reset; busy for exactly two cycles
        issue(1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge drpclk); check("id_busy1", 32'(busy_a), 32'd1);
        @(negedge drpclk); check("id_busy2", 32'(busy_a), 32'd1);
        @(negedge drpclk); check("id_busy3", 32'(busy_a), 32'd0);
        drain();

        // Write then read issued in the write's drprdy cycle
        issue(1'b0, 1'b1, 8'h5A, 16'hBEEF);
        repeat (2) @(posedge drpclk);
        #1;
        check("b2b_rdy_in_done", 32'(drprdy_a), 32'd1);
        issue(1'b0, 1'b0, 8'h5A, 16'h0000);
        drain();
        check("b2b_err", 32'(err_a), 32'd0);

        // Top address boundary
        issue(1'b0, 1'b1, 8'hFF, 16'h55AA);
        drain();
        issue(1'b0, 1'b0, 8'hFF, 16'h0000);
        drain();

        // Request while busy is dropped and sets err
        issue(1'b0, 1'b0, 8'h10, 16'h0000);
        drpwe = 1'b1; drpaddr = 8'h10; drpdi = 16'h1234; drpen_a = 1'b1;
        @(posedge drpclk);
        #1;
        drpen_a = 1'b0;
        check("viol_err", 32'(err_a), 32'd1);
        drain();
        issue(1'b0, 1'b0, 8'h10, 16'h0000);
        drain();
        check("viol_err_sticky", 32'(err_a), 32'd1);

        // Address 0 is read-only
        issue(1'b0, 1'b1, 8'h00, 16'hFFFF);
        drain();
        issue(1'b0, 1'b0, 8'h00, 16'h0000);
        drain();

        // Reset mid-transaction aborts the write and clears the bank
        issue(1'b0, 1'b1, 8'h22, 16'hCAFE);
        rst_n = 1'b0;
        sb_a.delete();
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge drpclk);
            check("abort_no_rdy", 32'(drprdy_a), 32'd0);
        end
        check("abort_err_clr", 32'(err_a), 32'd0);
        @(posedge drpclk);
        #1;
        rst_n = 1'b1;
        issue(1'b0, 1'b0, 8'h22, 16'h0000);
        drain();
        check("post_rst_err", 32'(err_a), 32'd0);

        // LATENCY=1: 8 back-to-back writes then 8 back-to-back reads
        for (int i = 0; i < 8; i++) issue(1'b1, 1'b1, b_addrs[i], 16'($urandom));
        for (int i = 0; i < 8; i++) issue(1'b1, 1'b0, b_addrs[i], 16'h0000);
        drain();
        check("b_err", 32'(err_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
